reg_move_sequencer: RTL and testbench

Sequences one 8-bit register-to-register move (MOV8) on the shared data bus of the register unit. It drives the one-hot select and load strobes of registers A, B, C, D, M1, M2, X and Y. The order is fixed: the source is selected first, the destination load is pulsed while the source is still selected, then load drops before select drops. It sits between the instruction decoder and the register unit's control bus.

---
 rtl/reg_unit_pkg.sv | 32 +++
 rtl/reg_move_sequencer_if.sv | 20 ++
 rtl/phase_counter.sv | 28 ++
 rtl/reg_move_sequencer.sv | 172 +++++++++++++++++
 tb/tb_reg_move_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_unit_pkg.sv
// Shared register-unit definitions: register codes, move-sequencer states
// and the code-to-one-hot strobe decoder.
package reg_unit_pkg;

   typedef enum logic [2:0] {
      REG_A  = 3'd0,
      REG_B  = 3'd1,
      REG_C  = 3'd2,
      REG_D  = 3'd3,
      REG_M1 = 3'd4,
      REG_M2 = 3'd5,
      REG_X  = 3'd6,
      REG_Y  = 3'd7
   } reg_code_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOAD  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } mov_state_t;

   // Bit n of the result is set for register code n.
   function automatic logic [7:0] onehot8(input reg_code_t code);
      logic [7:0] v;
      v       = 8'h00;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/reg_move_sequencer_if.sv
// Control bus between the instruction decoder (master) and the move
// sequencer (slave): request with operand codes in, strobes and status out.
interface reg_move_sequencer_if;
   import reg_unit_pkg::*;

   logic      req;
   reg_code_t src;
   reg_code_t dst;
   logic      busy;
   logic      done;
   logic [7:0] sel;
   logic [7:0] ld;

   modport master (output req, output src, output dst,
                   input  busy, input done, input sel, input ld);

   modport slave  (input  req, input src, input dst,
                   output busy, output done, output sel, output ld);

endinterface

// File: rtl/phase_counter.sv
// Phase timer shared by all timed phases of the move: counts up from zero
// and flags when the count matches the terminal value of the current phase.
module phase_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_tc,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Restart at zero on every phase entry, otherwise advance once per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_cnt <= r_cnt + CNT_W'(1'b1);
      end
   end

   assign o_tc = (r_cnt == i_tc);

endmodule

// File: rtl/reg_move_sequencer.sv
// MOV8 sequencer: drives source select and destination load strobes of the
// register unit in the order select -> load -> drop load -> drop select.
// All strobes are registered and decoded from the next state so that they
// change exactly on the edge where the phase changes.
module reg_move_sequencer #(
   parameter int SEL_SETUP = 1,
   parameter int LD_WIDTH  = 2,
   parameter int SEL_HOLD  = 1,
   parameter int CNT_W     = 4
) (
   input logic                  clk,
   input logic                  reset,
   reg_move_sequencer_if.slave  io_mov
);
   import reg_unit_pkg::*;

   // A phase ends when the counter reaches its length minus one.
   localparam logic [CNT_W-1:0] TC_SETUP = CNT_W'(SEL_SETUP - 1);
   localparam logic [CNT_W-1:0] TC_LOAD  = CNT_W'(LD_WIDTH - 1);
   localparam logic [CNT_W-1:0] TC_HOLD  = CNT_W'(SEL_HOLD - 1);

   mov_state_t       r_state;
   mov_state_t       w_state_nxt;
   reg_code_t        r_src;
   reg_code_t        r_dst;
   reg_code_t        w_src_nxt;
   reg_code_t        w_dst_nxt;
   logic             w_tc;
   logic             w_cnt_clr;
   logic [CNT_W-1:0] w_tc_val;
   logic [7:0]       w_sel_nxt;
   logic [7:0]       w_ld_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [7:0]       r_sel;
   logic [7:0]       r_ld;
   logic             r_busy;
   logic             r_done;

   phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_cnt_clr),
      .i_tc  (w_tc_val),
      .o_tc  (w_tc)
   );

   // Pick the terminal count belonging to the phase currently running.
   always_comb begin
      w_tc_val = {CNT_W{1'b0}};
      case (r_state)
         ST_SETUP: w_tc_val = TC_SETUP;
         ST_LOAD:  w_tc_val = TC_LOAD;
         ST_HOLD:  w_tc_val = TC_HOLD;
         default:  w_tc_val = {CNT_W{1'b0}};
      endcase
   end

   // The counter is held at zero while idle and restarted on every transition.
   assign w_cnt_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE);

   // Next-state logic; operands are captured only when a request is accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      case (r_state)
         ST_IDLE: begin
            if (io_mov.req) begin
               w_state_nxt = ST_SETUP;
               w_src_nxt   = io_mov.src;
               w_dst_nxt   = io_mov.dst;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (w_tc) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_SETUP;
            end
         end
         ST_LOAD: begin
            if (w_tc) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_HOLD: begin
            if (w_tc) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobe decode for the coming cycle. When source equals destination the
   // select stays off so the idle bus (0x00) is loaded: a register clear.
   always_comb begin
      w_sel_nxt  = 8'h00;
      w_ld_nxt   = 8'h00;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (w_state_nxt)
         ST_SETUP, ST_HOLD: begin
            w_busy_nxt = 1'b1;
            if (w_src_nxt != w_dst_nxt) begin
               w_sel_nxt = onehot8(w_src_nxt);
            end else begin
               w_sel_nxt = 8'h00;
            end
         end
         ST_LOAD: begin
            w_busy_nxt = 1'b1;
            w_ld_nxt   = onehot8(w_dst_nxt);
            if (w_src_nxt != w_dst_nxt) begin
               w_sel_nxt = onehot8(w_src_nxt);
            end else begin
               w_sel_nxt = 8'h00;
            end
         end
         ST_DONE: begin
            w_busy_nxt = 1'b1;
            w_done_nxt = 1'b1;
         end
         default: begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b0;
         end
      endcase
   end

   // FSM state and latched operand codes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_src   <= REG_A;
         r_dst   <= REG_A;
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
      end
   end

   // Output registers; reset clears every strobe immediately, abandoning a move.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel  <= 8'h00;
         r_ld   <= 8'h00;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sel  <= w_sel_nxt;
         r_ld   <= w_ld_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign io_mov.sel  = r_sel;
   assign io_mov.ld   = r_ld;
   assign io_mov.busy = r_busy;
   assign io_mov.done = r_done;

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Directed bench for reg_move_sequencer: a default-parameter instance and a
// SEL_SETUP=3/LD_WIDTH=1/SEL_HOLD=2 instance, each with a behavioural
// register-unit model whose expected contents are queued per move.
module tb_reg_move_sequencer;
   import reg_unit_pkg::*;

   typedef struct packed {
      logic [2:0] dst;
      logic [7:0] val;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] regs1 [8];
   logic [7:0] regs2 [8];
   sb_t        q1 [$];
   sb_t        q2 [$];
   logic       clr1;
   logic       clr2;
   logic [7:0] p_sel1, p_ld1, p_sel2, p_ld2;
   logic [2:0] hs [4];
   logic [2:0] hd [4];

   reg_move_sequencer_if u_if1 ();
   reg_move_sequencer_if u_if2 ();

   reg_move_sequencer u_dut1 (
      .clk    (clk),
      .reset  (reset),
      .io_mov (u_if1)
   );

   reg_move_sequencer #(
      .SEL_SETUP (3),
      .LD_WIDTH  (1),
      .SEL_HOLD  (2),
      .CNT_W     (4)
   ) u_dut2 (
      .clk    (clk),
      .reset  (reset),
      .io_mov (u_if2)
   );

   always #5 clk = ~clk;

   function automatic int idx8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [7:0] init_val(input int i);
      return 8'h59 + 8'(i);
   endfunction

   // Expected {busy, done, sel, ld} in cycle k after the accepting edge.
   function automatic logic [17:0] exp_out(input int k, input int ss, input int lw,
                                           input int sh, input logic [2:0] s,
                                           input logic [2:0] d);
      logic [7:0] e_sel, e_ld;
      logic       e_busy, e_done;
      int         t;
      t      = ss + lw + sh + 1;
      e_sel  = 8'h00;
      e_ld   = 8'h00;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (k >= 1 && k <= t) e_busy = 1'b1;
      if (k == t) e_done = 1'b1;
      if (k >= 1 && k <= ss + lw + sh && s != d) e_sel = 8'h01 << s;
      if (k > ss && k <= ss + lw) e_ld = 8'h01 << d;
      return {e_busy, e_done, e_sel, e_ld};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Register-unit models: the selected register drives the bus, an idle bus
   // reads 0x00, and the loaded register captures the bus at the clock edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs1[i] <= init_val(i);
      end else if (u_if1.ld != 8'h00) begin
         regs1[idx8(u_if1.ld)] <= (u_if1.sel != 8'h00) ? regs1[idx8(u_if1.sel)] : 8'h00;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs2[i] <= init_val(i);
      end else if (u_if2.ld != 8'h00) begin
         regs2[idx8(u_if2.ld)] <= (u_if2.sel != 8'h00) ? regs2[idx8(u_if2.sel)] : 8'h00;
      end
   end

   // Strobe invariants for both instances, checked every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk("inv1_onehot0_sel", 32'($onehot0(u_if1.sel)), 32'd1);
         chk("inv1_onehot0_ld", 32'($onehot0(u_if1.ld)), 32'd1);
         chk("inv1_ld_without_sel", 32'((u_if1.ld != 8'h00) && (u_if1.sel == 8'h00) && !clr1), 32'd0);
         chk("inv1_ld_sel_rise_together",
             32'(((u_if1.ld & ~p_ld1) != 8'h00) && ((u_if1.sel & ~p_sel1) != 8'h00)), 32'd0);
         chk("inv2_onehot0_sel", 32'($onehot0(u_if2.sel)), 32'd1);
         chk("inv2_onehot0_ld", 32'($onehot0(u_if2.ld)), 32'd1);
         chk("inv2_ld_without_sel", 32'((u_if2.ld != 8'h00) && (u_if2.sel == 8'h00) && !clr2), 32'd0);
         chk("inv2_ld_sel_rise_together",
             32'(((u_if2.ld & ~p_ld2) != 8'h00) && ((u_if2.sel & ~p_sel2) != 8'h00)), 32'd0);
      end
      p_sel1 <= u_if1.sel;
      p_ld1  <= u_if1.ld;
      p_sel2 <= u_if2.sel;
      p_ld2  <= u_if2.ld;
   end

   // Compare one cycle of a move; a done pulse retires the oldest queued move.
   task automatic check_cycle(input int dut, input int k, input logic [2:0] s,
                              input logic [2:0] d, input string tag);
      logic [17:0] o, e;
      sb_t         item;
      if (dut == 1) begin
         o = {u_if1.busy, u_if1.done, u_if1.sel, u_if1.ld};
         e = exp_out(k, 1, 2, 1, s, d);
      end else begin
         o = {u_if2.busy, u_if2.done, u_if2.sel, u_if2.ld};
         e = exp_out(k, 3, 1, 2, s, d);
      end
      chk($sformatf("%s_k%0d_sel", tag, k), 32'(o[15:8]), 32'(e[15:8]));
      chk($sformatf("%s_k%0d_ld", tag, k), 32'(o[7:0]), 32'(e[7:0]));
      chk($sformatf("%s_k%0d_busy", tag, k), 32'(o[17]), 32'(e[17]));
      chk($sformatf("%s_k%0d_done", tag, k), 32'(o[16]), 32'(e[16]));
      if (o[16]) begin
         if (dut == 1) begin
            chk($sformatf("%s_sb_pending", tag), 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
               item = q1.pop_front();
               chk($sformatf("%s_dst_value", tag), 32'(regs1[item.dst]), 32'(item.val));
            end
         end else begin
            chk($sformatf("%s_sb_pending", tag), 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
               item = q2.pop_front();
               chk($sformatf("%s_dst_value", tag), 32'(regs2[item.dst]), 32'(item.val));
            end
         end
      end
   endtask

   // One isolated move: single-cycle request, then operands scrambled.
   task automatic run_move(input int dut, input logic [2:0] s, input logic [2:0] d,
                           input string tag);
      int  t;
      sb_t item;
      t = (dut == 1) ? 5 : 7;
      @(negedge clk);
      item.dst = d;
      if (dut == 1) begin
         item.val = (s == d) ? 8'h00 : regs1[s];
         q1.push_back(item);
         clr1 = (s == d);
         u_if1.req = 1'b1;
         u_if1.src = reg_code_t'(s);
         u_if1.dst = reg_code_t'(d);
      end else begin
         item.val = (s == d) ? 8'h00 : regs2[s];
         q2.push_back(item);
         clr2 = (s == d);
         u_if2.req = 1'b1;
         u_if2.src = reg_code_t'(s);
         u_if2.dst = reg_code_t'(d);
      end
      for (int k = 1; k <= t + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (dut == 1) begin
               u_if1.req = 1'b0;
               u_if1.src = reg_code_t'(~s);
               u_if1.dst = reg_code_t'(~d);
            end else begin
               u_if2.req = 1'b0;
               u_if2.src = reg_code_t'(~s);
               u_if2.dst = reg_code_t'(~d);
            end
         end
         check_cycle(dut, k, s, d, tag);
      end
   endtask

   initial begin
      int  ndone_all;
      int  ndone_win;
      sb_t item;

      reset     = 1'b1;
      clr1      = 1'b0;
      clr2      = 1'b0;
      u_if1.req = 1'b0;
      u_if1.src = REG_A;
      u_if1.dst = REG_A;
      u_if2.req = 1'b0;
      u_if2.src = REG_A;
      u_if2.dst = REG_A;

      // Reset state.
      #8;
      chk("rst_sel", 32'(u_if1.sel), 32'd0);
      chk("rst_ld", 32'(u_if1.ld), 32'd0);
      chk("rst_busy", 32'(u_if1.busy), 32'd0);
      chk("rst_done", 32'(u_if1.done), 32'd0);
      chk("rst2_sel", 32'(u_if2.sel), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // B -> C with defaults: C must capture 0x5A.
      run_move(1, 3'd1, 3'd2, "mov_b_c");
      chk("mov_b_c_reg_c", 32'(regs1[2]), 32'h5A);

      // D -> D is a clear.
      run_move(1, 3'd3, 3'd3, "clr_d");
      chk("clr_d_reg_d", 32'(regs1[3]), 32'h00);
      clr1 = 1'b0;

      // req held high for 20 edges with operands changing every cycle.
      ndone_all = 0;
      ndone_win = 0;
      @(negedge clk);
      for (int c = 0; c <= 24; c++) begin
         if (c >= 1) begin
            check_cycle(1, (c - 1) % 6 + 1, hs[(c - 1) / 6], hd[(c - 1) / 6], "held");
            if (u_if1.done) begin
               ndone_all++;
               if (c <= 20) ndone_win++;
            end
         end
         if (c < 20) begin
            u_if1.req = 1'b1;
            u_if1.src = reg_code_t'(3'(c % 8));
            u_if1.dst = reg_code_t'(3'((c + 5) % 8));
            if (c % 6 == 0) begin
               hs[c / 6] = 3'(c % 8);
               hd[c / 6] = 3'((c + 5) % 8);
               item.dst  = 3'((c + 5) % 8);
               item.val  = regs1[3'(c % 8)];
               q1.push_back(item);
            end
         end else begin
            u_if1.req = 1'b0;
         end
         if (c < 24) @(negedge clk);
      end
      chk("held_moves_in_20_cycles", 32'(ndone_win), 32'd3);
      chk("held_moves_total", 32'(ndone_all), 32'd4);

      // Reset during LOAD of B -> C.
      @(negedge clk);
      u_if1.req = 1'b1;
      u_if1.src = REG_B;
      u_if1.dst = REG_C;
      @(negedge clk);
      u_if1.req = 1'b0;
      check_cycle(1, 1, 3'd1, 3'd2, "abort");
      @(negedge clk);
      check_cycle(1, 2, 3'd1, 3'd2, "abort");
      #2;
      reset = 1'b1;
      #1;
      chk("abort_async_sel", 32'(u_if1.sel), 32'd0);
      chk("abort_async_ld", 32'(u_if1.ld), 32'd0);
      chk("abort_async_busy", 32'(u_if1.busy), 32'd0);
      chk("abort_async_done", 32'(u_if1.done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(u_if1.done), 32'd0);
         chk("abort_idle_busy", 32'(u_if1.busy), 32'd0);
      end
      run_move(1, 3'd1, 3'd2, "after_abort");

      // Non-default timing: Y -> A.
      run_move(2, 3'd7, 3'd0, "mov_y_a");
      chk("mov_y_a_reg_a", 32'(regs2[0]), 32'h60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
